// File: rtl/fifo_read_checker.sv
// Read-side consumer for the dual-clock FIFO: paced pops, display of each accepted word, sequence checking.
// Optional macro RD_STOP_ON_ERR_EN: freeze on the first sequence error until Reset.
module fifo_read_checker #(
  parameter int unsigned DSIZE       = 16,
  parameter int unsigned HOLD_CYCLES = 10000000,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [DSIZE-1:0] sortida_lectura,
  output logic             word_valid,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [DSIZE-1:0] last_bad
);

  localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    SEED,
    FETCH,
    HOLD
`ifdef RD_STOP_ON_ERR_EN
    , STOPPED
`endif
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [DSIZE-1:0] expected;
  logic             bad_word;

  // The seed word is never checked; only FETCH accepts compare against expected.
  always_comb begin
    bad_word = (state == FETCH) && (rdata != expected);
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= SEED;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEED, FETCH: begin
        if (rinc) begin
          if (HOLD_CYCLES == 0) state_nxt = FETCH;
          else                  state_nxt = HOLD;
`ifdef RD_STOP_ON_ERR_EN
          if (bad_word) state_nxt = STOPPED;
`endif
        end
      end
      HOLD: begin
        if (hold_cnt == '0) state_nxt = FETCH;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    rinc = ((state == SEED) || (state == FETCH)) && !rempty;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hold_cnt        <= '0;
      expected        <= '0;
      sortida_lectura <= '0;
      word_valid      <= 1'b0;
      mismatch        <= 1'b0;
      err_count       <= '0;
      last_bad        <= '0;
    end else begin
      word_valid <= 1'b0;
      if ((state == HOLD) && (hold_cnt != '0)) hold_cnt <= hold_cnt - 1'b1;
      if (rinc) begin
        sortida_lectura <= rdata;
        word_valid      <= 1'b1;
        hold_cnt        <= HOLD_LOAD;
        // Resynchronise on the received word so a single drop costs one error.
        expected        <= rdata + 1'b1;
        if (bad_word) begin
          mismatch <= 1'b1;
          last_bad <= rdata;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_checker.sv
// Bench for fifo_read_checker: two instances (HOLD_CYCLES=3 and 0) fed from queue-like FIFO models,
// checked every cycle against a time-since-last-accept reference model plus constant vector tables.
module tb_fifo_read_checker;

  localparam int unsigned H0    = 3;
  localparam int unsigned H1    = 0;
  localparam int unsigned DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rdata_s  [2];
  logic        rempty_s [2];
  logic        rinc_w   [2];
  logic [15:0] disp     [2];
  logic        wv       [2];
  logic        mis      [2];
  logic [7:0]  errc     [2];
  logic [15:0] bad      [2];

  always #5 clk = ~clk;

  fifo_read_checker #(.DSIZE(16), .HOLD_CYCLES(H0), .ERR_W(8)) u_h3 (
    .Clk(clk), .Reset(rst), .rdata(rdata_s[0]), .rempty(rempty_s[0]), .rinc(rinc_w[0]),
    .sortida_lectura(disp[0]), .word_valid(wv[0]), .mismatch(mis[0]), .err_count(errc[0]),
    .last_bad(bad[0])
  );

  fifo_read_checker #(.DSIZE(16), .HOLD_CYCLES(H1), .ERR_W(8)) u_h0 (
    .Clk(clk), .Reset(rst), .rdata(rdata_s[1]), .rempty(rempty_s[1]), .rinc(rinc_w[1]),
    .sortida_lectura(disp[1]), .word_valid(wv[1]), .mismatch(mis[1]), .err_count(errc[1]),
    .last_bad(bad[1])
  );

  // FIFO contents as a circular buffer per instance
  logic [15:0] mem [2][DEPTH];
  int unsigned wp [2];
  int unsigned rp [2];

  // reference model
  bit          seeded   [2];
  bit          stopped  [2];
  bit          have_acc [2];
  int unsigned last_acc [2];
  logic [15:0] exp_w    [2];
  logic [15:0] m_disp   [2];
  logic [15:0] m_bad    [2];
  logic        m_valid  [2];
  logic        m_mis    [2];
  logic [7:0]  m_err    [2];
  int unsigned cyc;

  int unsigned n_chk;
  int unsigned n_pass;
  int unsigned pulses  [2];
  int unsigned run     [2];
  int unsigned max_run [2];
  int unsigned n_rinc  [2];

  typedef struct {
    int unsigned         dut;
    int unsigned         n;
    logic [7:0][15:0]    w;
    int unsigned         cycles;
    logic [15:0]         disp;
    logic [7:0]          err;
    logic                mis;
    logic [15:0]         bad;
    int unsigned         pulses;
    int unsigned         run;
  } vec_t;

  vec_t tbl [4];

  function automatic int unsigned hold_of(int k);
    return (k == 0) ? H0 : H1;
  endfunction

  function automatic bit fifo_empty(int k);
    return wp[k] == rp[k];
  endfunction

  task automatic push(int k, logic [15:0] w);
    if (wp[k] - rp[k] < DEPTH) begin
      mem[k][wp[k] % DEPTH] = w;
      wp[k]++;
    end
  endtask

  task automatic drive_fifo();
    for (int k = 0; k < 2; k++) begin
      rempty_s[k] = fifo_empty(k);
      rdata_s[k]  = fifo_empty(k) ? 16'hDEAD : mem[k][rp[k] % DEPTH];
    end
  endtask

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, req);
  endtask

  // A pop is allowed once at least HOLD+1 cycles have elapsed since the previous accept.
  function automatic bit model_rinc(int k);
    if (fifo_empty(k) || stopped[k]) return 1'b0;
    if (!have_acc[k]) return 1'b1;
    return (cyc - last_acc[k]) >= hold_of(k) + 1;
  endfunction

  task automatic model_edge(int k, bit r, bit acc, logic [15:0] w);
    if (r) begin
      seeded[k] = 0; stopped[k] = 0; have_acc[k] = 0; last_acc[k] = 0;
      exp_w[k] = '0; m_disp[k] = '0; m_bad[k] = '0;
      m_valid[k] = 1'b0; m_mis[k] = 1'b0; m_err[k] = '0;
    end else begin
      m_valid[k] = 1'b0;
      if (acc) begin
        m_valid[k] = 1'b1;
        m_disp[k]  = w;
        if (seeded[k] && (w != exp_w[k])) begin
          m_mis[k] = 1'b1;
          m_bad[k] = w;
          if (m_err[k] != 8'hFF) m_err[k] = m_err[k] + 8'd1;
`ifdef RD_STOP_ON_ERR_EN
          stopped[k] = 1;
`endif
        end
        exp_w[k]    = 16'(w + 16'd1);
        seeded[k]   = 1;
        have_acc[k] = 1;
        last_acc[k] = cyc;
      end
    end
  endtask

  // One clock cycle: inputs settle, rinc checked mid-cycle, outputs checked 1 time unit after the edge.
  task automatic step();
    bit          pr   [2];
    logic [15:0] hw   [2];
    logic        took [2];
    bit          r;
    drive_fifo();
    #4;
    r = rst;
    for (int k = 0; k < 2; k++) begin
      pr[k]   = model_rinc(k);
      hw[k]   = rdata_s[k];
      took[k] = rinc_w[k];
      if (!r) chk("rinc", k, 32'(rinc_w[k]), 32'(pr[k]));
      if (!r && rinc_w[k] === 1'b1) begin
        run[k]++;
        n_rinc[k]++;
        if (run[k] > max_run[k]) max_run[k] = run[k];
      end else begin
        run[k] = 0;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      model_edge(k, r, pr[k], hw[k]);
      if (took[k] === 1'b1 && !fifo_empty(k)) rp[k]++;
    end
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("sortida_lectura", k, 32'(disp[k]), 32'(m_disp[k]));
      chk("word_valid",      k, 32'(wv[k]),   32'(m_valid[k]));
      chk("mismatch",        k, 32'(mis[k]),  32'(m_mis[k]));
      chk("err_count",       k, 32'(errc[k]), 32'(m_err[k]));
      chk("last_bad",        k, 32'(bad[k]),  32'(m_bad[k]));
      if (wv[k] === 1'b1) pulses[k]++;
    end
    drive_fifo();
  endtask

  task automatic clear_counts();
    for (int k = 0; k < 2; k++) begin
      pulses[k] = 0; run[k] = 0; max_run[k] = 0; n_rinc[k] = 0;
    end
  endtask

  task automatic apply_reset();
    for (int k = 0; k < 2; k++) rp[k] = wp[k];
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_counts();
  endtask

  function automatic vec_t mk(int unsigned dut, int unsigned n, logic [7:0][15:0] w,
                              int unsigned cycles, logic [15:0] d, logic [7:0] e, logic m,
                              logic [15:0] b, int unsigned p, int unsigned rn);
    vec_t v;
    v.dut = dut; v.n = n; v.w = w; v.cycles = cycles; v.disp = d; v.err = e;
    v.mis = m; v.bad = b; v.pulses = p; v.run = rn;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] next_w [2];
    logic [15:0] w;
    bit          seen;
    vec_t        v;

    n_chk = 0; n_pass = 0; cyc = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wp[k] = 0; rp[k] = 0;
      model_edge(k, 1'b1, 1'b0, 16'h0);
    end
    clear_counts();
    drive_fifo();
    @(posedge clk);
    #1;

    // Words listed first-to-pop from the left.
    tbl[0] = mk(0, 3, {16'h0005, 16'h0006, 16'h0007, 80'd0}, 20,
                16'h0007, 8'd0, 1'b0, 16'h0000, 3, 1);
    tbl[1] = mk(1, 8, {16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                       16'h0000, 16'h0001, 16'h0002, 16'h0003}, 12,
                16'h0003, 8'd0, 1'b0, 16'h0000, 8, 8);
`ifdef RD_STOP_ON_ERR_EN
    tbl[2] = mk(0, 4, {16'h0010, 16'h0011, 16'h0013, 16'h0014, 64'd0}, 24,
                16'h0013, 8'd1, 1'b1, 16'h0013, 3, 1);
    tbl[3] = mk(1, 4, {16'h0001, 16'h0002, 16'h0004, 16'h0005, 64'd0}, 10,
                16'h0004, 8'd1, 1'b1, 16'h0004, 3, 3);
`else
    tbl[2] = mk(0, 4, {16'h0010, 16'h0011, 16'h0013, 16'h0014, 64'd0}, 24,
                16'h0014, 8'd1, 1'b1, 16'h0013, 4, 1);
    tbl[3] = mk(1, 4, {16'h0001, 16'h0002, 16'h0004, 16'h0005, 64'd0}, 10,
                16'h0005, 8'd1, 1'b1, 16'h0004, 4, 4);
`endif

    for (int i = 0; i < 4; i++) begin
      v = tbl[i];
      apply_reset();
      for (int j = 0; j < int'(v.n); j++) push(int'(v.dut), v.w[7-j]);
      repeat (v.cycles) step();
      chk("vec_disp",   int'(v.dut), 32'(disp[v.dut]), 32'(v.disp));
      chk("vec_err",    int'(v.dut), 32'(errc[v.dut]), 32'(v.err));
      chk("vec_mis",    int'(v.dut), 32'(mis[v.dut]),  32'(v.mis));
      chk("vec_bad",    int'(v.dut), 32'(bad[v.dut]),  32'(v.bad));
      chk("vec_pulses", int'(v.dut), pulses[v.dut],    v.pulses);
      chk("vec_run",    int'(v.dut), max_run[v.dut],   v.run);
    end

    // FIFO empty for 20 cycles after reset, then a single seed word.
    apply_reset();
    repeat (20) step();
    for (int k = 0; k < 2; k++) begin
      chk("idle_rinc", k, n_rinc[k], 0);
      chk("idle_disp", k, 32'(disp[k]), 0);
      chk("idle_err",  k, 32'(errc[k]), 0);
    end
    push(0, 16'h1234);
    repeat (3) step();
    chk("seed_disp",   0, 32'(disp[0]), 32'h1234);
    chk("seed_err",    0, 32'(errc[0]), 0);
    chk("seed_mis",    0, 32'(mis[0]),  0);
    chk("seed_pulses", 0, pulses[0],    1);

    // Reset coinciding with an active pop.
    apply_reset();
    push(0, 16'h0100);
    push(0, 16'h0101);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive_fifo();
      #1;
      if (rinc_w[0] === 1'b1) begin
        seen = 1;
        break;
      end
      step();
    end
    chk("rst_pop_seen", 0, 32'(seen), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_pop_valid", 0, 32'(wv[0]),   0);
    chk("rst_pop_disp",  0, 32'(disp[0]), 0);
    step();
    chk("rst_next_disp",  0, 32'(disp[0]), 32'h0101);
    chk("rst_next_valid", 0, 32'(wv[0]),   1);
    chk("rst_next_err",   0, 32'(errc[0]), 0);

    // Random: mostly incrementing with occasional skips.
    apply_reset();
    for (int k = 0; k < 2; k++) next_w[k] = 16'($urandom);
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 2) == 0) begin
          w = next_w[k];
          if ($urandom_range(0, 9) == 0) w = 16'(w + 16'($urandom_range(1, 3)));
          push(k, w);
          next_w[k] = 16'(w + 16'd1);
        end
      end
      step();
    end

    // Random: arbitrary words, dense on the back-to-back instance so err_count saturates.
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      push(1, 16'($urandom));
      if ($urandom_range(0, 2) == 0) push(0, 16'($urandom));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
